// File: rtl/immediate_generator_rv32.sv
// -----------------------------------------------------------------------------
// immediate_generator_rv32
//
// Decode-stage immediate extractor for RV32I. Picks the I/S/B/U/J immediate
// out of a 32-bit instruction word, based only on the opcode, and
// sign-extends it to a 32-bit operand. The result feeds the ALU operand mux
// and the branch/jump target adder.
//
// Parameters
//   REGISTER_OUTPUT : 0 -> imm_out, imm_type and valid_out are combinational
//                          (zero latency; clk and rst have no effect)
//                     1 -> outputs are registered (one cycle of latency)
//
// Ports
//   clk       in   1   rising-edge clock (only matters when REGISTER_OUTPUT=1)
//   rst       in   1   asynchronous, active-high reset
//   instr     in  32   instruction word
//   valid_in  in   1   instr is valid this cycle
//   imm_out   out 32   decoded immediate
//   valid_out out  1   imm_out is valid
//   imm_type  out  3   0 none, 1 I, 2 S, 3 B, 4 U, 5 J (6 CSR uimm)
//
// Build option
//   IMM_GEN_ZICSR_EN : when defined, SYSTEM opcode 1110011 is decoded.
//                      funct3 101/110/111 gives the 5-bit CSR uimm
//                      (imm_type 6). Other funct3 values decode as I-type.
//                      When undefined, SYSTEM is an unknown opcode.
// -----------------------------------------------------------------------------
module immediate_generator_rv32 #(
    parameter int REGISTER_OUTPUT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        valid_in,
    output logic [31:0] imm_out,
    output logic        valid_out,
    output logic [2:0]  imm_type
);

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
`ifdef IMM_GEN_ZICSR_EN
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
`endif

    localparam logic [2:0] T_NONE = 3'd0;
    localparam logic [2:0] T_I    = 3'd1;
    localparam logic [2:0] T_S    = 3'd2;
    localparam logic [2:0] T_B    = 3'd3;
    localparam logic [2:0] T_U    = 3'd4;
    localparam logic [2:0] T_J    = 3'd5;
`ifdef IMM_GEN_ZICSR_EN
    localparam logic [2:0] T_CSR  = 3'd6;
`endif

    logic [6:0]  opcode;
    logic [31:0] imm_d;
    logic [2:0]  type_d;
    logic [31:0] imm_q;
    logic [2:0]  type_q;
    logic        valid_q;

    assign opcode = instr[6:0];

    // Only the opcode steers the decode; each branch touches only the bits of
    // its own format, so unknown bits elsewhere in instr cannot leak through.
    always_comb begin
        imm_d  = 32'd0;
        type_d = T_NONE;
        case (opcode)
            OP_IMM, OP_LOAD, OP_JALR: begin
                // Shift-immediate forms are deliberately not special-cased.
                imm_d  = {{20{instr[31]}}, instr[31:20]};
                type_d = T_I;
            end
            OP_STORE: begin
                imm_d  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                type_d = T_S;
            end
            OP_BRANCH: begin
                imm_d  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                          instr[11:8], 1'b0};
                type_d = T_B;
            end
            OP_LUI, OP_AUIPC: begin
                imm_d  = {instr[31:12], 12'd0};
                type_d = T_U;
            end
            OP_JAL: begin
                imm_d  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                          instr[30:21], 1'b0};
                type_d = T_J;
            end
`ifdef IMM_GEN_ZICSR_EN
            OP_SYSTEM: begin
                // funct3 = 1xx with a non-zero low pair selects the
                // immediate CSR forms (CSRRWI/CSRRSI/CSRRCI).
                if (instr[14] && (instr[13:12] != 2'b00)) begin
                    imm_d  = {27'd0, instr[19:15]};
                    type_d = T_CSR;
                end else begin
                    imm_d  = {{20{instr[31]}}, instr[31:20]};
                    type_d = T_I;
                end
            end
`endif
            default: begin
                imm_d  = 32'd0;
                type_d = T_NONE;
            end
        endcase
    end

    // Output register: valid follows valid_in every edge, the payload only
    // loads on a valid cycle and otherwise holds the last decoded value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            imm_q   <= 32'd0;
            type_q  <= T_NONE;
        end else begin
            valid_q <= valid_in;
            if (valid_in) begin
                imm_q  <= imm_d;
                type_q <= type_d;
            end
        end
    end

    // In the combinational build the register above has no load and is
    // removed by synthesis.
    assign imm_out   = (REGISTER_OUTPUT != 0) ? imm_q   : imm_d;
    assign imm_type  = (REGISTER_OUTPUT != 0) ? type_q  : type_d;
    assign valid_out = (REGISTER_OUTPUT != 0) ? valid_q : valid_in;

endmodule

// File: tb/tb_immediate_generator_rv32.sv
module tb_immediate_generator_rv32;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] imm;
        logic [2:0]  typ;
    } vec_t;

    localparam int NVEC = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic [31:0] instr_c = 32'd0;
    logic        valid_c = 1'b0;
    logic [31:0] imm_c;
    logic        vout_c;
    logic [2:0]  type_c;

    logic [31:0] instr_r = 32'd0;
    logic        valid_r = 1'b0;
    logic [31:0] imm_r;
    logic        vout_r;
    logic [2:0]  type_r;

    int total = 0;
    int bad   = 0;

    vec_t tv [NVEC];

    always #5 clk = ~clk;

    immediate_generator_rv32 #(.REGISTER_OUTPUT(0)) u_comb (
        .clk       (clk),
        .rst       (rst),
        .instr     (instr_c),
        .valid_in  (valid_c),
        .imm_out   (imm_c),
        .valid_out (vout_c),
        .imm_type  (type_c)
    );

    immediate_generator_rv32 #(.REGISTER_OUTPUT(1)) u_reg (
        .clk       (clk),
        .rst       (rst),
        .instr     (instr_r),
        .valid_in  (valid_r),
        .imm_out   (imm_r),
        .valid_out (vout_r),
        .imm_type  (type_r)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    initial begin
        // Directed vectors with hand-computed expectations.
        tv[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 3'd1};  // addi -1
        tv[1]  = '{32'h00000093, 32'h00000000, 3'd1};  // addi 0
        tv[2]  = '{32'h00A00093, 32'h0000000A, 3'd1};  // addi 10
        tv[3]  = '{32'hFE112C23, 32'hFFFFFFF8, 3'd2};  // sw -8
        tv[4]  = '{32'h00208063, 32'h00000000, 3'd3};  // beq 0
        tv[5]  = '{32'h00208463, 32'h00000008, 3'd3};  // beq +8
        tv[6]  = '{32'hFE208CE3, 32'hFFFFFFF8, 3'd3};  // beq -8
        tv[7]  = '{32'h123450B7, 32'h12345000, 3'd4};  // lui
        tv[8]  = '{32'h12345097, 32'h12345000, 3'd4};  // auipc
        tv[9]  = '{32'h0010006F, 32'h00000800, 3'd5};  // jal +2048
        tv[10] = '{32'h801FFFEF, 32'hFFFFF800, 3'd5};  // jal -2048
        tv[11] = '{32'h0000007F, 32'h00000000, 3'd0};  // unknown opcode
        tv[12] = '{32'hFFC4A303, 32'hFFFFFFFC, 3'd1};  // lw -4
        tv[13] = '{32'h7FF08067, 32'h000007FF, 3'd1};  // jalr +2047
`ifdef IMM_GEN_ZICSR_EN
        tv[14] = '{32'h3000D073, 32'h00000001, 3'd6};  // csrrwi uimm=1
        tv[15] = '{32'h30009073, 32'h00000300, 3'd1};  // csrrw -> I-type
`else
        tv[14] = '{32'h3000D073, 32'h00000000, 3'd0};  // SYSTEM unknown
        tv[15] = '{32'h30009073, 32'h00000000, 3'd0};
`endif

        // Asynchronous reset before any clock edge.
        #1 rst = 1'b1;
        #1;
        check("reset_imm",   imm_r,          32'd0);
        check("reset_type",  {29'd0, type_r}, 32'd0);
        check("reset_valid", {31'd0, vout_r}, 32'd0);

        // Combinational build: valid passes straight through.
        valid_c = 1'b1;
        #1 check("comb_valid_hi", {31'd0, vout_c}, 32'd1);
        valid_c = 1'b0;
        #1 check("comb_valid_lo", {31'd0, vout_c}, 32'd0);

        // Release reset away from the clock edge.
        @(negedge clk);
        rst = 1'b0;

        // First valid result one edge after valid_in.
        instr_r = 32'hFFF00093;
        valid_r = 1'b1;
        @(posedge clk);
        #1;
        check("first_imm",   imm_r,           32'hFFFFFFFF);
        check("first_type",  {29'd0, type_r}, 32'd1);
        check("first_valid", {31'd0, vout_r}, 32'd1);

        // valid_in=0: payload holds, valid drops.
        instr_r = 32'h123450B7;
        valid_r = 1'b0;
        @(posedge clk);
        #1;
        check("hold_imm",   imm_r,           32'hFFFFFFFF);
        check("hold_type",  {29'd0, type_r}, 32'd1);
        check("hold_valid", {31'd0, vout_r}, 32'd0);

        // Table sweep through both instances.
        for (int i = 0; i < NVEC; i++) begin
            instr_c = tv[i].instr;
            instr_r = tv[i].instr;
            valid_r = 1'b1;
            #1;
            check($sformatf("comb_imm[%0d]", i),  imm_c,           tv[i].imm);
            check($sformatf("comb_type[%0d]", i), {29'd0, type_c}, {29'd0, tv[i].typ});
            @(posedge clk);
            #1;
            check($sformatf("reg_imm[%0d]", i),   imm_r,           tv[i].imm);
            check($sformatf("reg_type[%0d]", i),  {29'd0, type_r}, {29'd0, tv[i].typ});
            check($sformatf("reg_valid[%0d]", i), {31'd0, vout_r}, 32'd1);
        end

        // Bits outside the U field are unknown; result must still be exact.
        instr_c = {20'hABCDE, 5'bxxxxx, 7'b0110111};
        #1;
        check("x_tolerant_imm",  imm_c,           32'hABCDE000);
        check("x_tolerant_type", {29'd0, type_c}, 32'd4);

        // Mid-cycle reset discards the held value immediately.
        instr_r = 32'h801FFFEF;
        valid_r = 1'b1;
        @(posedge clk);
        #1 check("pre_rst_imm", imm_r, 32'hFFFFF800);
        #2 rst = 1'b1;
        #1;
        check("midrst_imm",   imm_r,           32'd0);
        check("midrst_type",  {29'd0, type_r}, 32'd0);
        check("midrst_valid", {31'd0, vout_r}, 32'd0);

        // An edge while reset is held still leaves everything cleared.
        @(posedge clk);
        #1;
        check("rst_held_imm",   imm_r,           32'd0);
        check("rst_held_valid", {31'd0, vout_r}, 32'd0);

        // Release; the first edge with valid_in=1 loads the new value.
        @(negedge clk);
        rst = 1'b0;
        instr_r = 32'hFE112C23;
        @(posedge clk);
        #1;
        check("post_rst_imm",   imm_r,           32'hFFFFFFF8);
        check("post_rst_type",  {29'd0, type_r}, 32'd2);
        check("post_rst_valid", {31'd0, vout_r}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
